// File: rtl/effect_regfile_responder.sv
// effect_regfile_responder: responder side of the effect register-RAM strobe
// interface. It holds a 2^ADDR_W x DATA_W register bank that is shared with a
// single-cycle host port, and keeps a hardware-owned output-ready flag/irq.
//
// Ports:
//   clk, reset            system clock, asynchronous active-low reset
//   loc_ramaddress        effect address (also selects combinational read data)
//   loc_writedata         effect write data
//   loc_ramclk            effect access strobe; its rising level change fires
//   loc_ramread           accepted but unused; the effect read path is continuous
//   loc_ramwrite          effect write qualifier, sampled at the fire edge
//   loc_readdata          effect read data, combinational from loc_ramaddress
//   host_addr/wdata/we/re host single-cycle access (we/re are one-cycle pulses)
//   host_rdata/rvalid     registered read data, plus its one-cycle valid pulse
//   host_collision        one-cycle pulse: host write lost to a same-address effect write
//   irq                   level, mirrors the ready flag
module effect_regfile_responder #(
  parameter int ADDR_W     = 5,
  parameter int DATA_W     = 32,
  parameter int OUT_ADDR   = 5,
  parameter int READY_ADDR = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] loc_ramaddress,
  input  logic [DATA_W-1:0] loc_writedata,
  input  logic              loc_ramclk,
  input  logic              loc_ramread,
  input  logic              loc_ramwrite,
  output logic [DATA_W-1:0] loc_readdata,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  input  logic              host_we,
  input  logic              host_re,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              host_collision,
  output logic              irq
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] OUT_A   = ADDR_W'(OUT_ADDR);
  localparam logic [ADDR_W-1:0] READY_A = ADDR_W'(READY_ADDR);

  logic [DATA_W-1:0] mem [DEPTH];
  logic              ramclk_q;
  logic              ready_flag;

  // The effect read strobe carries no information: reads are continuous.
  logic unused_ramread;
  assign unused_ramread = loc_ramread;

  // Strobe rising-edge detect; a held-high strobe fires only once.
  logic fire;
  assign fire = loc_ramclk & ~ramclk_q;

  // The ready register is read-only from both sides, so writes to it are
  // filtered out before they can reach the bank or the collision detector.
  logic eff_wr, host_wr, collide;
  assign eff_wr  = fire & loc_ramwrite & (loc_ramaddress != READY_A);
  assign host_wr = host_we & (host_addr != READY_A);
  assign collide = eff_wr & host_wr & (loc_ramaddress == host_addr);

  logic flag_set, flag_clr;
  assign flag_set = eff_wr & (loc_ramaddress == OUT_A);
  assign flag_clr = host_re & (host_addr == OUT_A);

  // Read muxes: the ready register shows the flag in bit 0, zeros elsewhere.
  logic [DATA_W-1:0] flag_word;
  logic [DATA_W-1:0] host_rd_mux;
  assign flag_word    = {{(DATA_W-1){1'b0}}, ready_flag};
  assign loc_readdata = (loc_ramaddress == READY_A) ? flag_word : mem[loc_ramaddress];
  assign host_rd_mux  = (host_addr == READY_A) ? flag_word : mem[host_addr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      // Host write goes first; the effect write is last so it wins a collision.
      if (host_wr && !collide) mem[host_addr] <= host_wdata;
      if (eff_wr)              mem[loc_ramaddress] <= loc_writedata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ramclk_q       <= 1'b0;
      ready_flag     <= 1'b0;
      host_rdata     <= '0;
      host_rvalid    <= 1'b0;
      host_collision <= 1'b0;
    end else begin
      ramclk_q       <= loc_ramclk;
      host_rvalid    <= host_re;
      host_collision <= collide;
      // host_rdata holds until the next read; the value is the pre-edge contents.
      if (host_re) host_rdata <= host_rd_mux;
      // Set beats clear: a new sample arriving during the clearing read keeps the flag up.
      if (flag_set)      ready_flag <= 1'b1;
      else if (flag_clr) ready_flag <= 1'b0;
    end
  end

  assign irq = ready_flag;

endmodule

// File: tb/tb_effect_regfile_responder.sv
// Bench for effect_regfile_responder: directed vectors, host reads checked by a
// scoreboard queue popped by a monitor; other outputs checked directly.
module tb_effect_regfile_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  loc_ramaddress;
  logic [31:0] loc_writedata;
  logic        loc_ramclk;
  logic        loc_ramread;
  logic        loc_ramwrite;
  logic [31:0] loc_readdata;
  logic [4:0]  host_addr;
  logic [31:0] host_wdata;
  logic        host_we;
  logic        host_re;
  logic [31:0] host_rdata;
  logic        host_rvalid;
  logic        host_collision;
  logic        irq;

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  effect_regfile_responder dut (
    .clk(clk), .reset(reset),
    .loc_ramaddress(loc_ramaddress), .loc_writedata(loc_writedata),
    .loc_ramclk(loc_ramclk), .loc_ramread(loc_ramread), .loc_ramwrite(loc_ramwrite),
    .loc_readdata(loc_readdata),
    .host_addr(host_addr), .host_wdata(host_wdata), .host_we(host_we), .host_re(host_re),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid), .host_collision(host_collision),
    .irq(irq)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs are changed 1 time unit after the rising edge; checks happen there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every host_rvalid pulse consumes one expected read value.
  always @(negedge clk) begin
    if (reset === 1'b1 && host_rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL host_read_unexpected: got 0x%08h expected no read", host_rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (host_rdata !== e) begin
          failures++;
          $display("FAIL host_read: got 0x%08h expected 0x%08h", host_rdata, e);
        end
      end
    end
  end

  task automatic host_read(input logic [4:0] a, input logic [31:0] e);
    host_addr = a; host_re = 1'b1; exp_q.push_back(e);
    tick();
    host_re = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    loc_ramaddress = '0; loc_writedata = '0; loc_ramclk = 1'b0;
    loc_ramread = 1'b0; loc_ramwrite = 1'b0;
    host_addr = '0; host_wdata = '0; host_we = 1'b0; host_re = 1'b0;
    #12;
    check("rst_loc_readdata", loc_readdata, 32'h0);
    check("rst_host_rdata", host_rdata, 32'h0);
    check("rst_rvalid", {31'h0, host_rvalid}, 32'h0);
    check("rst_collision", {31'h0, host_collision}, 32'h0);
    check("rst_irq", {31'h0, irq}, 32'h0);
    reset = 1'b1;
    tick();

    // Effect read, then host write visible combinationally on the effect side.
    loc_ramaddress = 5'd2; loc_ramread = 1'b1;
    #1 check("eff_rd_addr2_init", loc_readdata, 32'h0);
    host_addr = 5'd2; host_wdata = 32'h0000_1234; host_we = 1'b1;
    tick();
    host_we = 1'b0;
    #1 check("eff_rd_addr2_hostwr", loc_readdata, 32'h0000_1234);

    // Effect write to OUT_ADDR, strobe held 3 cycles -> one write, flag set.
    loc_ramaddress = 5'd5; loc_writedata = 32'hCAFE_0001; loc_ramwrite = 1'b1; loc_ramclk = 1'b1;
    #1 check("eff_wr_before_edge", loc_readdata, 32'h0);
    tick();
    check("eff_wr_one_clk", loc_readdata, 32'hCAFE_0001);
    check("irq_set", {31'h0, irq}, 32'h1);
    loc_writedata = 32'hCAFE_0009;
    tick();
    tick();
    check("eff_wr_single_fire", loc_readdata, 32'hCAFE_0001);
    loc_ramclk = 1'b0; loc_ramwrite = 1'b0;
    tick();
    host_read(5'd6, 32'h1);

    // Host read of OUT_ADDR clears the flag.
    host_read(5'd5, 32'hCAFE_0001);
    check("irq_cleared", {31'h0, irq}, 32'h0);

    // Same-edge new sample and clearing read: old data returned, set wins.
    loc_ramaddress = 5'd5; loc_writedata = 32'hCAFE_0002; loc_ramwrite = 1'b1; loc_ramclk = 1'b1;
    host_read(5'd5, 32'hCAFE_0001);
    check("irq_set_wins", {31'h0, irq}, 32'h1);
    check("eff_wr_cafe0002", loc_readdata, 32'hCAFE_0002);
    loc_ramclk = 1'b0; loc_ramwrite = 1'b0;
    tick();

    // Same-address collision: effect wins, pulse next cycle.
    loc_ramaddress = 5'd3; loc_writedata = 32'hAAAA_AAAA; loc_ramwrite = 1'b1; loc_ramclk = 1'b1;
    host_addr = 5'd3; host_wdata = 32'h5555_5555; host_we = 1'b1;
    tick();
    host_we = 1'b0; loc_ramclk = 1'b0; loc_ramwrite = 1'b0;
    check("collision_pulse", {31'h0, host_collision}, 32'h1);
    check("collision_eff_wins", loc_readdata, 32'hAAAA_AAAA);
    host_read(5'd3, 32'hAAAA_AAAA);
    check("collision_pulse_end", {31'h0, host_collision}, 32'h0);

    // Different addresses: both commit, no pulse.
    loc_ramaddress = 5'd3; loc_writedata = 32'h1111_1111; loc_ramwrite = 1'b1; loc_ramclk = 1'b1;
    host_addr = 5'd4; host_wdata = 32'h2222_2222; host_we = 1'b1;
    tick();
    host_we = 1'b0; loc_ramclk = 1'b0; loc_ramwrite = 1'b0;
    check("no_collision", {31'h0, host_collision}, 32'h0);
    check("diff_addr_eff", loc_readdata, 32'h1111_1111);
    host_read(5'd4, 32'h2222_2222);

    // Strobe without write qualifier: nothing changes.
    loc_ramaddress = 5'd5; loc_writedata = 32'hDEAD_BEEF; loc_ramwrite = 1'b0; loc_ramclk = 1'b1;
    tick();
    check("no_wr_qual_mem", loc_readdata, 32'hCAFE_0002);
    check("no_wr_qual_irq", {31'h0, irq}, 32'h1);
    loc_ramclk = 1'b0;
    tick();

    // Writes to READY_ADDR from both ports in the same cycle: ignored, no pulse.
    loc_ramaddress = 5'd6; loc_writedata = 32'hFFFF_FFFF; loc_ramwrite = 1'b1; loc_ramclk = 1'b1;
    host_addr = 5'd6; host_wdata = 32'hFFFF_FFFF; host_we = 1'b1;
    tick();
    host_we = 1'b0; loc_ramclk = 1'b0; loc_ramwrite = 1'b0;
    check("ready_ro_eff", loc_readdata, 32'h1);
    check("ready_no_collision", {31'h0, host_collision}, 32'h0);
    check("ready_irq_kept", {31'h0, irq}, 32'h1);
    host_read(6'd6, 32'h1);
    tick();

    // Reset with the strobe high: outputs clear at once, one fire after release.
    loc_ramaddress = 5'd5; loc_writedata = 32'h0000_0077; loc_ramwrite = 1'b1; loc_ramclk = 1'b1;
    reset = 1'b0;
    #1;
    check("midrst_loc_readdata", loc_readdata, 32'h0);
    check("midrst_irq", {31'h0, irq}, 32'h0);
    check("midrst_host_rdata", host_rdata, 32'h0);
    check("midrst_rvalid", {31'h0, host_rvalid}, 32'h0);
    tick();
    check("in_rst_no_write", loc_readdata, 32'h0);
    reset = 1'b1;
    tick();
    check("post_rst_fire", loc_readdata, 32'h0000_0077);
    check("post_rst_irq", {31'h0, irq}, 32'h1);
    loc_writedata = 32'h0000_0088;
    tick();
    tick();
    check("post_rst_single_fire", loc_readdata, 32'h0000_0077);
    loc_ramclk = 1'b0; loc_ramwrite = 1'b0;
    tick();

    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/effect_regfile_responder.md
Name: effect_regfile_responder

Overview:
- Responder end of the effect-side register-RAM strobe interface. The effect master drives address, write data and the loc_ramclk/loc_ramwrite strobes; this block holds the 32x32 register bank behind them.
- Also exposes a host port (processor side) with single-cycle read/write to the same bank.
- Maintains a hardware-owned output-ready flag plus an interrupt, so the host knows when the effect has produced a new sample.

Parameters:
- ADDR_W, 5, register address width (2^ADDR_W entries)
- DATA_W, 32, register width
- OUT_ADDR, 5, output-sample register; an effect write here sets the ready flag
- READY_ADDR, 6, hardware-owned ready-flag register (bit0 = flag, other bits read 0)

Ports:
- clk  in  1  system clock; also clocks the effect master
- reset  in  1  asynchronous, active-low reset
- loc_ramaddress  in  ADDR_W  effect-side address
- loc_writedata  in  DATA_W  effect-side write data
- loc_ramclk  in  1  effect-side access strobe; the rising level change marks an access
- loc_ramread  in  1  accepted, functionally ignored (reads are continuous)
- loc_ramwrite  in  1  effect-side write qualifier
- loc_readdata  out  DATA_W  effect-side read data
- host_addr  in  ADDR_W  host address
- host_wdata  in  DATA_W  host write data
- host_we  in  1  host write request, one-cycle pulse per access
- host_re  in  1  host read request, one-cycle pulse per access
- host_rdata  out  DATA_W  host read data
- host_rvalid  out  1  one-cycle pulse; host_rdata valid
- host_collision  out  1  one-cycle pulse; host write dropped
- irq  out  1  level; equals ready flag

Behaviour:
- Reset (async, reset=0):
  - All registers, ramclk_q, ready flag, host_rdata, host_rvalid and host_collision go to 0.
  - loc_readdata therefore reads 0.
- Effect read path:
  - loc_readdata = mem[loc_ramaddress], purely combinational.
  - READY_ADDR reads {0..., flag}.
  - The master sets the address on one edge and samples on the next; the data must be valid within that same cycle.
- Effect strobe detect:
  - ramclk_q <= loc_ramclk every clk.
  - fire = loc_ramclk & ~ramclk_q.
  - On a clk edge where fire=1 and loc_ramwrite=1: mem[loc_ramaddress] <= loc_writedata. Write latency is one clk after loc_ramclk rises.
  - loc_ramclk held high for several cycles produces exactly one write.
  - Writes with loc_ramwrite=0 at the fire edge do nothing.
- Host write: host_we=1 → mem[host_addr] <= host_wdata at that edge.
- Host read:
  - host_re=1 → next cycle host_rdata = pre-edge mem[host_addr] and host_rvalid=1.
  - host_rdata holds its value until the next read.
  - host_we and host_re together: the read returns the old value and the write commits.
- READY_ADDR is read-only from both sides; writes to it from either port are ignored, with no collision pulse.
- Ready flag:
  - Set on an effect write to OUT_ADDR.
  - Cleared on a host read of OUT_ADDR.
  - If set and clear happen in the same cycle, set wins; the host receives the old sample value.
  - irq = flag, registered.
- Collision: an effect write and a host write to the same non-READY address in the same cycle → effect data wins, and host_collision pulses 1 the next cycle. Different addresses → both commit.
- Reset mid-access: any pending strobe is lost, and ramclk_q=0 after reset. If loc_ramclk is already high when reset releases, one fire occurs on the first post-reset edge. This is required: the master also restarts with ramclk=0, so no spurious write results in practice.
- Out-of-range: none; the address width covers the full bank.

Test Plan:
- Reset, then effect reads addr 2 with no strobe → loc_readdata=0; host writes addr 2 = 0x0000_1234, then loc_ramaddress=2 → loc_readdata=0x0000_1234 in the same cycle.
- Effect sequence: address=5, wdata=0xCAFE_0001, write=1, ramclk 0→1 held 3 cycles → mem[5]=0xCAFE_0001 one clk after the rise, exactly one write; flag and irq go to 1; host read of 6 returns 0x1.
- Host read of addr 5 with the flag set → host_rvalid pulse, host_rdata=0xCAFE_0001, irq=0 next cycle. Repeat with an effect write to addr 5 of 0xCAFE_0002 on the same edge → host_rdata=0xCAFE_0001, irq stays 1.
- Same-cycle effect write to addr 3 (0xAAAA_AAAA) and host write to addr 3 (0x5555_5555) → mem[3]=0xAAAA_AAAA, host_collision pulses; addresses 3 vs 4 → both commit, no pulse.
- Strobe with loc_ramwrite=0 to addr 5, and writes to addr 6 from either port → memory unchanged, flag unchanged.
- Assert reset mid-sequence with loc_ramclk=1 → all outputs 0 immediately; after release, behaviour is as specified (single fire).
